// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package arith_pkg;

    // Controller state encoding; the values are fixed so that other blocks
    // and debug tooling can decode the 2-bit state directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes bits 0..w-1. A zero-width counter is
    // not legal, so a 1-bit operand still gets a 1-bit counter.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell: s = a ^ b ^ c, co = majority(a, b, c).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell has no handshake.
//
// Ports:
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout, sum} = a + b + cin, one bit per clock, LSB first.
// Latency: start accepted at edge E0, done pulses after edge E_WIDTH (WIDTH+1 cycles per op back-to-back).
// Backpressure: start is only honoured in IDLE or DONE; it is ignored while busy.
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   start      : request; accepted on a rising edge in IDLE or DONE
//   a, b, cin  : operands, captured only on the accepting edge
//   busy       : high while the bits are being processed
//   done       : one-cycle pulse, result valid
//   sum, cout  : result, held until the next accepted start
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;

    // Bit-slice core outputs
    logic fa_s;
    logic fa_c;

    // A new operation is taken both from IDLE and from DONE, the latter
    // giving back-to-back operation with no idle cycle in between.
    logic accept;
    logic last_bit;

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (state_q == RUN) && (cnt_q == LAST);

    full_adder_1bit u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // ------------------------------------------------------------------
    // Next-state and counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                // The counter stops at LAST rather than wrapping, so it
                // always reads the index of the bit being processed.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Shift-register datapath
    // ------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            sum_d   = '0;
            cout_d  = 1'b0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            // New sum bit enters at the MSB; after WIDTH shifts the first
            // (LSB) result bit has arrived at position 0.
            sum_d            = sum_q >> 1;
            sum_d[WIDTH-1]   = fa_s;
            if (last_bit) begin
                cout_d = fa_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from registers, no input-to-output path
    // ------------------------------------------------------------------
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
